// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl_if
//  Description : Operand/result bundle for the bit-serial adder controller.
//                master : requester (drives start/a/b/cin, sees the result)
//                slave  : serial_add_ctrl
//  Signals     : start     - request an addition (acted on only when idle)
//                a, b      - WIDTH-bit operands
//                cin       - carry into bit 0
//                busy      - operation in flight (SHIFT or DONE)
//                done      - one-cycle result-valid pulse
//                sum       - WIDTH-bit result
//                cout      - carry out of the MSB
//                ovf       - two's-complement overflow
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fulladder
//  Description : One-bit combinational full adder.
//  Ports       : a, b, cin (in)  - addend bits and carry in
//                sum, cout (out) - sum bit and carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder controller. Captures a WIDTH-bit operand
//                pair on an accepted start, feeds the operands LSB-first
//                through a single full adder (one bit per clock, carry held
//                in a flop) and presents sum/cout/ovf with a one-cycle done.
//  Ports       : clk   (in)  - rising-edge clock
//                rst_n (in)  - synchronous active-low reset
//                bus   (slave modport of serial_add_ctrl_if)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   s_sr_q, s_sr_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_sum;
  logic               fa_cout;

  fulladder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        // Without start everything holds, so the last result stays visible.
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          s_sr_d  = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        // Sum bits enter at the MSB so bit 0 lands in s_sr[0] after WIDTH shifts.
        s_sr_d = {fa_sum, s_sr_q[WIDTH-1:1]};
        c_d    = fa_cout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // c_q here is the carry into the MSB.
          cout_d  = fa_cout;
          ovf_d   = c_q ^ fa_cout;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = s_sr_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl (WIDTH=4 and WIDTH=8
//                instances). Expected results come from an arithmetic model
//                and flow through per-instance scoreboard queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(4)) bus4 ();
  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();

  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference: full-precision addition, then signed overflow from operand signs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
    logic [32:0] full;
    exp_t        e;
    full   = {1'b0, a} + {1'b0, b} + 33'(cin);
    e.sum  = 8'(full[31:0] & ((32'd1 << w) - 32'd1));
    e.cout = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    return e;
  endfunction

  // Runs one WIDTH=4 operation; caller is at a negedge. Observes 8 cycles
  // after the accepting edge (ending in IDLE). With disturb, start/a/b/cin
  // are scrambled during SHIFT and DONE.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                     input bit disturb, output int done_k, output int n_done,
                     output int n_busy, output logic [3:0] s, output logic co,
                     output logic ov);
    done_k = 0; n_done = 0; n_busy = 0;
    s = 'x; co = 1'bx; ov = 1'bx;
    sb4.push_back(model(4, 32'(a), 32'(b), cin));
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus4.busy) n_busy++;
      if (bus4.done) begin
        n_done++;
        if (done_k == 0) begin
          done_k = k; s = bus4.sum; co = bus4.cout; ov = bus4.ovf;
        end
      end
      if (disturb && k <= 5) begin
        bus4.start = 1'($urandom_range(0, 1));
        bus4.a     = 4'($urandom);
        bus4.b     = 4'($urandom);
        bus4.cin   = 1'($urandom_range(0, 1));
      end else begin
        bus4.start = 1'b0;
      end
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     output bit seen, output logic [7:0] s, output logic co,
                     output logic ov);
    seen = 1'b0; s = 'x; co = 1'bx; ov = 1'bx;
    sb8.push_back(model(8, 32'(a), 32'(b), cin));
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int k = 1; k <= 14 && !seen; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        seen = 1'b1; s = bus8.sum; co = bus8.cout; ov = bus8.ovf;
      end
    end
    // Step out of DONE so the next request lands in IDLE.
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf} !== 8'b0) begin
      $display("FAIL reset_w4: got busy/done/sum/cout/ovf=%b want 0",
               {bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf});
    end else pass_cnt++;
    total_cnt++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 12'b0) begin
      $display("FAIL reset_w8: got busy/done/sum/cout/ovf=%b want 0",
               {bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf});
    end else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dk, nd, nb; logic [3:0] s; logic co, ov; exp_t e;
    op4(4'd5, 4'd3, 1'b0, 1'b0, dk, nd, nb, s, co, ov);
    e = sb4.pop_front();
    total_cnt++;
    if (dk !== 5) $display("FAIL basic_latency: got %0d want 5", dk); else pass_cnt++;
    total_cnt++;
    if (nd !== 1) $display("FAIL basic_done_width: got %0d want 1", nd); else pass_cnt++;
    total_cnt++;
    if (nb !== 5) $display("FAIL basic_busy_cycles: got %0d want 5", nb); else pass_cnt++;
    total_cnt++;
    if ({s, co, ov} !== {e.sum[3:0], e.cout, e.ovf})
      $display("FAIL basic_result: got sum=%0d cout=%b ovf=%b want sum=%0d cout=%b ovf=%b",
               s, co, ov, e.sum, e.cout, e.ovf);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    int dk, nd, nb; logic [3:0] s; logic co, ov; exp_t e;
    logic [8:0] vec [2];
    vec[0] = {4'd15, 4'd1, 1'b0};
    vec[1] = {4'd7,  4'd8, 1'b1};
    for (int i = 0; i < 2; i++) begin
      op4(vec[i][8:5], vec[i][4:1], vec[i][0], 1'b0, dk, nd, nb, s, co, ov);
      e = sb4.pop_front();
      total_cnt++;
      if (dk !== 5 || {s, co, ov} !== {e.sum[3:0], e.cout, e.ovf})
        $display("FAIL carry_%0d: got k=%0d sum=%0d cout=%b ovf=%b want k=5 sum=%0d cout=%b ovf=%b",
                 i, dk, s, co, ov, e.sum, e.cout, e.ovf);
      else pass_cnt++;
    end
  endtask

  task automatic test_disturb_and_hold();
    int dk, nd, nb; logic [3:0] s; logic co, ov; exp_t e;
    op4(4'd6, 4'd5, 1'b1, 1'b1, dk, nd, nb, s, co, ov);
    e = sb4.pop_front();
    total_cnt++;
    if (nd !== 1 || dk !== 5)
      $display("FAIL disturb_done: got pulses=%0d k=%0d want pulses=1 k=5", nd, dk);
    else pass_cnt++;
    total_cnt++;
    if ({s, co, ov} !== {e.sum[3:0], e.cout, e.ovf})
      $display("FAIL disturb_result: got sum=%0d cout=%b ovf=%b want sum=%0d cout=%b ovf=%b",
               s, co, ov, e.sum, e.cout, e.ovf);
    else pass_cnt++;
    bus4.a = 4'd9; bus4.b = 4'd9; bus4.cin = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({bus4.busy, bus4.sum, bus4.cout, bus4.ovf} !== {1'b0, e.sum[3:0], e.cout, e.ovf})
      $display("FAIL hold_idle: got busy=%b sum=%0d cout=%b ovf=%b want busy=0 sum=%0d cout=%b ovf=%b",
               bus4.busy, bus4.sum, bus4.cout, bus4.ovf, e.sum, e.cout, e.ovf);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n_seen = 0; exp_t e;
    for (int i = 0; i < 3; i++) sb4.push_back(model(4, 32'd1, 32'd2, 1'b0));
    bus4.a = 4'd1; bus4.b = 4'd2; bus4.cin = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (bus4.done) begin
        e = sb4.pop_front();
        total_cnt++;
        if (k !== 5 + 6 * n_seen || bus4.sum !== e.sum[3:0])
          $display("FAIL b2b_%0d: got k=%0d sum=%0d want k=%0d sum=%0d",
                   n_seen, k, bus4.sum, 5 + 6 * n_seen, e.sum);
        else pass_cnt++;
        n_seen++;
      end
    end
    bus4.start = 1'b0;
    total_cnt++;
    if (n_seen !== 3) begin
      $display("FAIL b2b_count: got %0d want 3", n_seen);
      sb4.delete();
    end else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus4.busy !== 1'b0) $display("FAIL b2b_stop: got busy=%b want 0", bus4.busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int nd = 0;
    bus4.a = 4'd7; bus4.b = 4'd0; bus4.cin = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total_cnt++;
    if ({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf} !== 8'b0)
      $display("FAIL midreset_state: got busy/done/sum/cout/ovf=%b want 0",
               {bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf});
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus4.done) nd++;
    end
    total_cnt++;
    if (nd !== 0) $display("FAIL midreset_no_done: got %0d pulses want 0", nd);
    else pass_cnt++;
  endtask

  task automatic test_after_reset();
    int dk, nd, nb; logic [3:0] s; logic co, ov; exp_t e;
    op4(4'd9, 4'd6, 1'b0, 1'b0, dk, nd, nb, s, co, ov);
    e = sb4.pop_front();
    total_cnt++;
    if (dk !== 5 || {s, co, ov} !== {e.sum[3:0], e.cout, e.ovf})
      $display("FAIL after_reset: got k=%0d sum=%0d cout=%b ovf=%b want k=5 sum=%0d cout=%b ovf=%b",
               dk, s, co, ov, e.sum, e.cout, e.ovf);
    else pass_cnt++;
  endtask

  task automatic test_random_w8();
    bit seen; logic [7:0] s; logic co, ov; exp_t e;
    logic [7:0] ra, rb; logic rc;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
      op8(ra, rb, rc, seen, s, co, ov);
      e = sb8.pop_front();
      total_cnt++;
      if (seen !== 1'b1) $display("FAIL rand_done_%0d: no done within bound", i);
      else pass_cnt++;
      total_cnt++;
      if ({co, s, ov} !== {e.cout, e.sum, e.ovf})
        $display("FAIL rand_result_%0d: a=%0d b=%0d cin=%b got {cout,sum}=%0d ovf=%b want {cout,sum}=%0d ovf=%b",
                 i, ra, rb, rc, {co, s}, ov, {e.cout, e.sum}, e.ovf);
      else pass_cnt++;
    end
  endtask

  initial begin
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_disturb_and_hold();
    test_back_to_back();
    test_reset_mid_op();
    test_after_reset();
    test_random_w8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
